// File: rtl/exec_unit_p.sv
// Parametrised execution unit: fetches operands over the BIU handshake, runs an
// 8-op ALU or signed/unsigned compare, writes arithmetic results back, reports flags.
module exec_unit_p #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] imm,
    output logic             biu_req,
    output logic [1:0]       biu_sel,
    input  logic             biu_ready,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_lt
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH_A = 3'd1;
    localparam logic [2:0] S_FETCH_B = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             fc_q, fc_d, fz_q, fz_d, flt_q, flt_d;
    logic             req_q, req_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_res_c;
    logic             alu_carry_c;
    logic [WIDTH:0]   ext_c;
    logic [SHW-1:0]   sh_c;
    logic             xfer_c;

    // ALU: ext_c carries the result plus the carry/borrow/shifted-out bit
    always_comb begin
        sh_c        = b_q[SHW-1:0];
        ext_c       = '0;
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        case (op_q)
            OP_ADD: begin
                ext_c       = {1'b0, a_q} + {1'b0, b_q};
                alu_res_c   = ext_c[WIDTH-1:0];
                alu_carry_c = ext_c[WIDTH];
            end
            OP_SUB: begin
                ext_c       = {1'b0, a_q} - {1'b0, b_q};
                alu_res_c   = ext_c[WIDTH-1:0];
                alu_carry_c = ext_c[WIDTH];
            end
            OP_AND: alu_res_c = a_q & b_q;
            OP_OR:  alu_res_c = a_q | b_q;
            OP_XOR: alu_res_c = a_q ^ b_q;
            OP_SHL: begin
                ext_c       = {1'b0, a_q} << sh_c;
                alu_res_c   = ext_c[WIDTH-1:0];
                alu_carry_c = ext_c[WIDTH];
            end
            OP_SHR: begin
                ext_c       = {a_q, 1'b0} >> sh_c;
                alu_res_c   = ext_c[WIDTH:1];
                alu_carry_c = ext_c[0];
            end
            default: alu_res_c = b_q;
        endcase
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        op_d    = op_q;
        imm_d   = imm_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        fc_d    = fc_q;
        fz_d    = fz_q;
        flt_d   = flt_q;
        err_d   = 1'b0;
        xfer_c  = (state_q == S_FETCH_A) || (state_q == S_FETCH_B) || (state_q == S_WRITE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    op_d    = opcode;
                    imm_d   = imm;
                    state_d = S_FETCH_A;
                end
            end
            S_FETCH_A: begin
                if (biu_ready) begin
                    a_d = rd_data;
                    case (mode_q)
                        2'b00: begin
                            b_d     = imm_q;
                            state_d = S_EXEC;
                        end
                        2'b11: begin
                            b_d     = '0;
                            state_d = S_EXEC;
                        end
                        default: state_d = S_FETCH_B;
                    endcase
                end
            end
            S_FETCH_B: begin
                if (biu_ready) begin
                    b_d     = rd_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!mode_q[1]) begin
                    res_d   = alu_res_c;
                    fc_d    = alu_carry_c;
                    fz_d    = (alu_res_c == '0);
                    state_d = S_WRITE;
                end else begin
                    fz_d    = (a_q == b_q);
                    fc_d    = (a_q < b_q);
                    flt_d   = ($signed(a_q) < $signed(b_q));
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (biu_ready) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Wait-cycle watchdog; abandons the operation with no result or flag change
        if (TO_EN && xfer_c && !biu_ready) begin
            if (cnt_q == TO_LAST) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
        if (state_d != state_q) cnt_d = '0;

        req_d  = (state_d == S_FETCH_A) || (state_d == S_FETCH_B) || (state_d == S_WRITE);
        sel_d  = (state_d == S_FETCH_B) ? 2'b01 : ((state_d == S_WRITE) ? 2'b10 : 2'b00);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            op_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            flt_q   <= 1'b0;
            req_q   <= 1'b0;
            sel_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
            fz_q    <= fz_d;
            flt_q   <= flt_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign biu_req = req_q;
    assign biu_sel = sel_q;
    assign wr_data = res_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign flag_c  = fc_q;
    assign flag_z  = fz_q;
    assign flag_lt = flt_q;

endmodule

// File: tb/tb_exec_unit_p.sv
// Bench for exec_unit_p: directed vector table, timeout/reset/restart sequences,
// and randomized operations against an arithmetic reference model.
module tb_exec_unit_p;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [2:0]  opcode;
    logic [15:0] imm;
    logic        biu_req;
    logic [1:0]  biu_sel;
    logic        biu_ready;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic        busy, done, err, flag_c, flag_z, flag_lt;

    exec_unit_p #(.WIDTH(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .opcode(opcode), .imm(imm),
        .biu_req(biu_req), .biu_sel(biu_sel), .biu_ready(biu_ready), .rd_data(rd_data),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err),
        .flag_c(flag_c), .flag_z(flag_z), .flag_lt(flag_lt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Observations from the last operation
    int          r_done, r_err, r_nwrite;
    bit          r_hs, r_req_end;
    logic [15:0] r_wval;
    logic        r_busy_after, r_done_after, r_err_after;

    // Drives one operation and acts as the BIU, inserting the requested wait cycles
    task automatic run_op(input logic [1:0] m, input logic [2:0] op, input logic [15:0] im,
                          input logic [15:0] a, input logic [15:0] b,
                          input int wa, input int wb, input int ww, input bit restart);
        int cyc, waited, w;
        bit prev_pend;
        logic [1:0] prev_sel;
        logic [15:0] prev_wd;
        r_done = -1; r_err = -1; r_nwrite = 0; r_hs = 1'b1; r_wval = '0; r_req_end = 1'b0;
        waited = 0; prev_pend = 1'b0; prev_sel = 2'b00; prev_wd = '0;
        @(negedge clk);
        start = 1'b1; mode = m; opcode = op; imm = im; biu_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            biu_ready = 1'b0;
            if (err) begin r_err = cyc; r_req_end = biu_req; break; end
            if (done) begin r_done = cyc; r_req_end = biu_req; break; end
            if (prev_pend && (!biu_req || biu_sel != prev_sel || (biu_sel == 2'b10 && wr_data != prev_wd)))
                r_hs = 1'b0;
            if (biu_req) begin
                if (biu_sel == 2'b10) begin
                    if (!prev_pend) r_nwrite++;
                    r_wval = wr_data;
                end
                w = (biu_sel == 2'b00) ? wa : ((biu_sel == 2'b01) ? wb : ww);
                if (waited >= w) begin
                    biu_ready = 1'b1;
                    rd_data   = (biu_sel == 2'b00) ? a : b;
                    waited    = 0;
                    prev_pend = 1'b0;
                end else begin
                    rd_data   = 16'($urandom);
                    waited++;
                    prev_pend = 1'b1;
                end
                prev_sel = biu_sel;
                prev_wd  = wr_data;
            end else begin
                prev_pend = 1'b0;
            end
        end
        if (r_done < 0 && r_err < 0) $display("FAIL run_op_timeout actual=%0d required=%0d", cyc, 0);
        if (restart) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_busy_after = busy; r_done_after = done; r_err_after = err;
    endtask

    task automatic verify(input string tag, input int exp_cyc, input bit arith,
                          input logic [15:0] exp_wr, input logic c, input logic z, input logic lt);
        chk({tag, " done_cycle"}, 32'(r_done), 32'(exp_cyc));
        chk({tag, " no_err"}, 32'(r_err), 32'hFFFF_FFFF);
        chk({tag, " writes"}, 32'(r_nwrite), arith ? 32'd1 : 32'd0);
        if (arith) chk({tag, " wr_data"}, 32'(r_wval), 32'(exp_wr));
        chk({tag, " flags_c_z_lt"}, {29'd0, flag_c, flag_z, flag_lt}, {29'd0, c, z, lt});
        chk({tag, " post_busy_done"}, {30'd0, r_busy_after, r_done_after}, 32'd0);
        chk({tag, " handshake_stable"}, 32'(r_hs), 32'd1);
    endtask

    // Reference model: flags persist across operations like the architectural flags
    logic        m_c, m_z, m_lt;
    logic [15:0] m_res;

    function automatic void model(input logic [1:0] m, input logic [2:0] op,
                                  input logic [15:0] im, input logic [15:0] a, input logic [15:0] brd);
        int unsigned ua, ub, s, r;
        logic [15:0] b;
        b  = (m == 2'b00) ? im : ((m == 2'b11) ? 16'h0000 : brd);
        ua = a; ub = b; s = ub % 16;
        if (m[1]) begin
            m_z  = (ua == ub);
            m_c  = (ua < ub);
            m_lt = ($signed(a) < $signed(b));
        end else begin
            m_c = 1'b0;
            case (op)
                3'd0: begin r = ua + ub; m_c = (r > 65535); end
                3'd1: begin r = ua - ub; m_c = (ua < ub); end
                3'd2: r = ua & ub;
                3'd3: r = ua | ub;
                3'd4: r = ua ^ ub;
                3'd5: begin r = ua * (1 << s); m_c = (s != 0) && (((ua >> (16 - s)) & 1) == 1); end
                3'd6: begin r = ua / (1 << s); m_c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
                default: r = ub;
            endcase
            m_res = 16'(r % 65536);
            m_z   = (m_res == 16'h0000);
        end
    endfunction

    function automatic int exp_cycles(input logic [1:0] m, input int wa, input int wb, input int ww);
        case (m)
            2'b00:   return 4 + wa + ww;
            2'b01:   return 5 + wa + wb + ww;
            2'b10:   return 4 + wa + wb;
            default: return 3 + wa;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  m;
        logic [2:0]  op;
        logic [15:0] imm, a, b;
        int          wa, wb, ww;
        logic [15:0] wr;
        logic        c, z, lt;
        int          cyc;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] m, input logic [2:0] op, input logic [15:0] im,
                                input logic [15:0] a, input logic [15:0] b, input int wa, input int wb,
                                input int ww, input logic [15:0] wr, input logic c, input logic z,
                                input logic lt, input int cyc);
        vec_t v;
        v.m = m; v.op = op; v.imm = im; v.a = a; v.b = b; v.wa = wa; v.wb = wb; v.ww = ww;
        v.wr = wr; v.c = c; v.z = z; v.lt = lt; v.cyc = cyc;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        logic [1:0]  rm;
        logic [2:0]  rop;
        logic [15:0] rimm, ra, rb;
        int          rwa, rwb, rww;
        bit          saw;

        tbl[0]  = mk(2'b01, 3'd0, 16'h0000, 16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 1, 0, 5);
        tbl[1]  = mk(2'b00, 3'd5, 16'h0001, 16'h8001, 16'h0000, 0, 0, 0, 16'h0002, 1, 0, 0, 4);
        tbl[2]  = mk(2'b00, 3'd5, 16'h0000, 16'h8001, 16'h0000, 0, 0, 0, 16'h8001, 0, 0, 0, 4);
        tbl[3]  = mk(2'b10, 3'd0, 16'h0000, 16'hFFFE, 16'h0001, 0, 0, 0, 16'h0000, 0, 0, 1, 4);
        tbl[4]  = mk(2'b10, 3'd0, 16'h0000, 16'h0005, 16'h0005, 3, 3, 0, 16'h0000, 0, 1, 0, 10);
        tbl[5]  = mk(2'b01, 3'd1, 16'h0000, 16'h0003, 16'h0005, 0, 0, 2, 16'hFFFE, 1, 0, 0, 7);
        tbl[6]  = mk(2'b11, 3'd0, 16'h0000, 16'h8000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 3);
        tbl[7]  = mk(2'b00, 3'd4, 16'h00FF, 16'h00FF, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 1, 4);
        tbl[8]  = mk(2'b01, 3'd6, 16'h0000, 16'h0003, 16'h0011, 0, 0, 0, 16'h0001, 1, 0, 1, 5);
        tbl[9]  = mk(2'b01, 3'd7, 16'h0000, 16'h1234, 16'hABCD, 1, 0, 0, 16'hABCD, 0, 0, 1, 6);
        tbl[10] = mk(2'b00, 3'd3, 16'h00F0, 16'h0F00, 16'h0000, 0, 0, 1, 16'h0FF0, 0, 0, 1, 5);
        tbl[11] = mk(2'b00, 3'd2, 16'h0FF0, 16'hF0F0, 16'h0000, 0, 0, 0, 16'h00F0, 0, 0, 1, 4);

        rst = 1'b1; start = 1'b0; mode = '0; opcode = '0; imm = '0; biu_ready = 1'b0; rd_data = '0;
        @(posedge clk);
        #1;
        chk("reset_outputs", {biu_req, biu_sel, wr_data, busy, done, err, flag_c, flag_z, flag_lt},
            24'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].m, tbl[i].op, tbl[i].imm, tbl[i].a, tbl[i].b,
                   tbl[i].wa, tbl[i].wb, tbl[i].ww, 1'b0);
            verify($sformatf("vec%0d", i), tbl[i].cyc, !tbl[i].m[1], tbl[i].wr,
                   tbl[i].c, tbl[i].z, tbl[i].lt);
        end

        // FETCH_B never acknowledged: four idle edges then abort
        run_op(2'b10, 3'd0, 16'h0, 16'h0001, 16'h0002, 0, 1000, 0, 1'b0);
        chk("timeout err_cycle", 32'(r_err), 32'd6);
        chk("timeout no_done", 32'(r_done), 32'hFFFF_FFFF);
        chk("timeout req_dropped_busy_low", {30'd0, r_req_end, busy}, 32'd0);
        chk("timeout err_single_pulse", {31'd0, r_err_after}, 32'd0);
        chk("timeout flags_held", {29'd0, flag_c, flag_z, flag_lt}, 32'd1);

        // Start raised on the done edge must be ignored
        run_op(2'b11, 3'd0, 16'h0, 16'h0000, 16'h0, 0, 0, 0, 1'b1);
        verify("restart_at_done", 3, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("restart_ignored_req", {31'd0, biu_req}, 32'd0);

        // Asynchronous reset while the write transfer is pending
        @(negedge clk);
        start = 1'b1; mode = 2'b01; opcode = 3'd0; imm = '0;
        @(posedge clk);
        #1 start = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 20 && !saw; k++) begin
            @(negedge clk);
            biu_ready = 1'b0;
            if (biu_req && biu_sel == 2'b10) saw = 1'b1;
            else if (biu_req) begin biu_ready = 1'b1; rd_data = 16'h1111; end
        end
        chk("reset_in_write reached", 32'(saw), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("reset_in_write outputs", {biu_req, biu_sel, wr_data, busy, done, err, flag_c, flag_z, flag_lt},
            24'h0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy || err) saw = 1'b1;
        end
        chk("reset_in_write quiet", 32'(saw), 32'd0);
        m_c = 1'b0; m_z = 1'b0; m_lt = 1'b0; m_res = '0;
        model(2'b01, 3'd0, 16'h0, 16'h7000, 16'h9001);
        run_op(2'b01, 3'd0, 16'h0, 16'h7000, 16'h9001, 0, 0, 0, 1'b0);
        verify("after_reset", 5, 1'b1, m_res, m_c, m_z, m_lt);

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            rm   = 2'($urandom_range(0, 3));
            rop  = 3'($urandom_range(0, 7));
            rimm = 16'($urandom);
            ra   = 16'($urandom);
            rb   = (i % 5 == 0) ? ra : 16'($urandom);
            rwa  = $urandom_range(0, 2);
            rwb  = $urandom_range(0, 2);
            rww  = $urandom_range(0, 2);
            model(rm, rop, rimm, ra, rb);
            run_op(rm, rop, rimm, ra, rb, rwa, rwb, rww, 1'b0);
            verify($sformatf("rand%0d", i), exp_cycles(rm, rwa, rwb, rww), !rm[1], m_res, m_c, m_z, m_lt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exec_unit_p.md
# exec_unit_p

Parametrised execution unit for the MCU datapath, successor to the fixed 16-bit execution unit. It accepts a decoded operation from the control unit and fetches operands over a request/ready handshake with the bus interface unit (BIU). It then executes an ALU or compare operation internally, writes arithmetic results back through the BIU, and raises done, flag or error status. The block adds:
- generic width and an integrated 8-op ALU with shifts;
- signed compare;
- BIU timeout abort;
- split read/write data ports in place of a tri-state bus.

## Interface
Parameters:
- WIDTH, 16, datapath and operand width (≥4, power of two).
- TIMEOUT, 0, max cycles waiting on biu_ready per transfer; 0 disables timeout.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- mode  in  2  00 arith-immediate, 01 arith reg-reg, 10 compare reg-reg, 11 compare-with-zero.
- opcode  in  3  ALU op, used in arith modes.
- imm  in  WIDTH  immediate B operand for mode 00.
- biu_req  out  1  BIU transfer request.
- biu_sel  out  2  transfer type:
  - 00 read operand A;
  - 01 read operand B;
  - 10 write result.
- biu_ready  in  1  BIU transfer complete, valid on the same edge as rd_data.
- rd_data  in  WIDTH  BIU read data.
- wr_data  out  WIDTH  result to BIU; valid while biu_sel=10.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout-abort pulse.
- flag_c  out  1  carry/borrow flag.
- flag_z  out  1  zero/equal flag.
- flag_lt  out  1  signed less-than flag.

## Operation
- All outputs are registered.
- Reset values: every output 0; flags 0; operand registers 0; state IDLE.
- States: IDLE, FETCH_A, FETCH_B, EXEC, WRITE, DONE.
- IDLE: on start=1, latch mode, opcode and imm, then go to FETCH_A. start is ignored while busy.
- FETCH_A: biu_req=1, biu_sel=00. On an edge with biu_ready=1, capture A=rd_data and move on:
  - mode 01 or 10 → FETCH_B;
  - mode 00 → EXEC with B=imm;
  - mode 11 → EXEC with B=0.
- FETCH_B: biu_req=1, biu_sel=01. On an edge with biu_ready=1, capture B=rd_data and go to EXEC.
- EXEC: biu_req=0. Compute and go to WRITE (arith modes) or DONE (compare modes).
- Arith ops, result truncated to WIDTH:
  - 000 ADD: c = carry out.
  - 001 SUB: c = borrow, i.e. A<B unsigned.
  - 010 AND, 011 OR, 100 XOR, 111 PASS-B: c = 0.
  - 101 SHL by B[log2(WIDTH)-1:0]: c = last bit shifted out; shift amount 0 gives c=0.
  - 110 SHR (logical): same carry rule as SHL.
- Arith flag update: flag_z = (result==0); flag_c as listed above; flag_lt unchanged.
- Compare update, no writeback:
  - flag_z = (A==B);
  - flag_c = (A<B) unsigned;
  - flag_lt = (A<B) signed.
- WRITE: biu_req=1, biu_sel=10, wr_data=result. On biu_ready=1, go to DONE.
- DONE: done=1 for one cycle, then IDLE. Flags hold until the next EXEC or reset.
- Timeout (TIMEOUT>0): a counter clears on entering each FETCH_A, FETCH_B or WRITE state and increments each cycle biu_ready=0.
  - On reaching TIMEOUT: pulse err for one cycle, drop biu_req, return to IDLE.
  - No flag or result update occurs; done stays low.
- biu_ready outside FETCH_A, FETCH_B and WRITE is ignored.
- Reset asserted mid-operation aborts immediately to reset values. No done or err is produced.

## Timing
- start is sampled at edge 0. With zero-wait BIU (biu_ready high in the first request cycle), done is high in:
  - cycle 5 for mode 01;
  - cycle 4 for mode 00;
  - cycle 3 for mode 11;
  - cycle 4 for mode 10.
- Each BIU wait cycle adds one cycle.
- Handshake rules:
  - biu_req is asserted in the first cycle of a transfer state.
  - biu_req stays high with stable biu_sel and wr_data until the edge where biu_ready=1.
  - Back-to-back transfers (FETCH_A→FETCH_B) keep biu_req high; only biu_sel changes.
- busy rises the cycle after the start edge and falls in the cycle after done.
- A start coincident with done is ignored; a new start is accepted in the next IDLE cycle.

## Test plan
- Mode 01, opcode ADD, WIDTH=16, A=0xFFFF, B=0x0001, zero-wait BIU → wr_data=0x0000, flag_c=1, flag_z=1, done in cycle 5.
- Mode 00, opcode SHL, A=0x8001, imm=0x0001 → wr_data=0x0002, flag_c=1. Same test with imm=0 → wr_data=0x8001, flag_c=0.
- Mode 10, A=0xFFFE, B=0x0001 → flag_z=0, flag_c=0, flag_lt=1, no write transfer.
- Mode 10, 3 BIU wait cycles on each read → done in cycle 10. biu_req stays high throughout the waits with stable biu_sel.
- TIMEOUT=4, biu_ready never asserted in FETCH_B → err pulses once, done=0, previous flags held, busy falls.
- Reset asserted during WRITE → all outputs 0 asynchronously, no done. Next start completes normally.
